i2c_master_core: RTL and testbench
==================================

# i2c_master_core

Single-byte I2C bus master: on a one-cycle `enable` request it issues START, a 7-bit address plus R/W bit, then one data byte (written from `data_in` or read into `data_out`), then STOP. It sits between a register/bridge front end and the physical open-drain SCL/SDA pins, and raises `done` when the bus transaction completes. Only one master on the bus; there is no clock stretching and no arbitration.

## Interface
- `CLK_DIV`, default 4: system clocks per SCL half-period; legal range ≥2.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `addr` input 7: slave address, sent MSB first.
- `data_in` input 8: write byte, sent MSB first.
- `enable` input 1: start request, sampled only in IDLE.
- `rw` input 1: 0 = write, 1 = read; sent as the 8th address bit.
- `i2c_scl` output 1: serial clock, driven push-pull.
- `i2c_sda` inout 1: open-drain; master drives 0 or Z, never 1. External pull-up required.
- `done` output 1: high from STOP completion until the next accepted `enable`.
- `data_out` output 8: last byte read; updated only by a read transaction.

## Operation
- State register `state[2:0]`: IDLE=000, START=001, ADDR=010, WRITE_DATA=011, READ_DATA=100, ADDR_ACK=101, DATA_ACK=110, STOP=111. The encodings and the 3-bit `bit_count` register name are fixed; benches probe them hierarchically.
- IDLE: SCL=1, SDA released. If `enable`=1, latch `{addr,rw}` and `data_in`, clear `done`, go to START.
- START: SDA low while SCL high, then SCL low, then go to ADDR.
- ADDR: shift 8 bits, address MSB first then R/W. `bit_count` counts 0..7. Then go to ADDR_ACK.
- ADDR_ACK: release SDA for one SCL period and sample on SCL rising edge. Then go to WRITE_DATA if rw=0, else READ_DATA.
- WRITE_DATA: shift the latched byte, MSB first, 8 bits. Then go to DATA_ACK, where SDA is released and sampled.
- READ_DATA: release SDA. Sample bit `7-bit_count` on each SCL rising edge. After bit 7, load `data_out`, then go to DATA_ACK, where the master drives NACK (releases SDA).
- STOP: SDA low while SCL low, SCL high, then SDA released while SCL high. Set `done`, go to IDLE.
- `enable` outside IDLE is ignored. Inputs may change after acceptance without effect.
- Reset (any time): state=IDLE, `bit_count`=0, SCL=1, SDA=Z, `done`=0, `data_out`=8'h00.

## Timing
- One bit time = 2×CLK_DIV clocks. SCL is low for the first half and high for the second half.
- SDA changes only while SCL is low. The only exceptions are the START and STOP edges.
- Inputs are sampled at the SCL low→high transition.
- First START edge: 1 clock after `enable` is sampled.
- Total transaction: START (1 bit time) + 18 bit times + STOP (1 bit time) = 20×2×CLK_DIV clocks ±1. With the default, this is 160 clocks.
- `done` rises on the clock where STOP completes. It stays high until the clock after the next accepted `enable`.

## Configuration
- `I2C_MASTER_ACK_CHECK_EN` defined: if the ADDR_ACK sample (or the DATA_ACK sample on a write) is 1 (NACK), go directly to STOP. The remaining bits are skipped, `done` still asserts, and `data_out` is unchanged.
- Not defined: ACK samples are ignored and the full sequence always runs.

## Test plan
- Reset low mid-ADDR → next clock: SCL=1, SDA=Z, `done`=0, `data_out`=00, state=000.
- Write: addr=7'h55, rw=0, data_in=8'hA5, one-cycle `enable` → SDA bits 1010101 0, ACK slot, 10100101, ACK slot. STOP follows, then `done`=1 after about 160 clocks.
- Read: addr=7'h55, rw=1; slave drives 8'h5A during READ_DATA → `data_out`=8'h5A, `done`=1; master NACKs.
- `enable` pulsed during an active transaction → ignored: bit stream unchanged, exactly one `done` assertion.
- Back-to-back: write then read → `done` clears on the second accept; `data_out` unchanged by the write.
- With `I2C_MASTER_ACK_CHECK_EN`, no slave (SDA pulled high at ADDR_ACK) → STOP immediately after ADDR_ACK, `done`=1, `data_out` unchanged.

Source files
------------

// File: rtl/i2c_master_core_if.sv
// Front-end side of the I2C master: request fields in, completion and read data out.
interface i2c_master_core_if;
  logic [6:0] addr;
  logic [7:0] data_in;
  logic       enable;
  logic       rw;
  logic       done;
  logic [7:0] data_out;

  modport master (
    output addr, data_in, enable, rw,
    input  done, data_out
  );

  modport slave (
    input  addr, data_in, enable, rw,
    output done, data_out
  );
endinterface

// File: rtl/i2c_master_core.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK, STOP; 20 bit times per request.
// Define I2C_MASTER_ACK_CHECK_EN to jump straight to STOP when the address phase is NACKed.
module i2c_master_core #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  i2c_master_core_if.slave   bus,
  output logic               i2c_scl,
  inout  wire                i2c_sda
);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    START      = 3'b001,
    ADDR       = 3'b010,
    WRITE_DATA = 3'b011,
    READ_DATA  = 3'b100,
    ADDR_ACK   = 3'b101,
    DATA_ACK   = 3'b110,
    STOP       = 3'b111
  } state_t;

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);

  state_t        state, state_d;
  logic [2:0]    bit_count, bit_count_d;
  logic [CW-1:0] div_q, div_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    dout_q, dout_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
`ifdef I2C_MASTER_ACK_CHECK_EN
  logic          ack_q, ack_d;
`endif

  logic sda_in;
  logic bit_end;
  logic tx_bit;
  logic scl_hi_half;

  assign sda_in      = i2c_sda;
  assign bit_end     = (div_q == LAST);
  assign scl_hi_half = (div_q >= HALF);
  assign tx_bit      = (state == ADDR) ? addr_q[3'd7 - bit_count] : data_q[3'd7 - bit_count];

  always_comb begin
    state_d     = state;
    bit_count_d = bit_count;
    div_d       = bit_end ? '0 : div_q + 1'b1;
    addr_d      = addr_q;
    data_d      = data_q;
    rx_d        = rx_q;
    dout_d      = dout_q;
    done_d      = done_q;
    scl_d       = scl_hi_half;
    // SDA holds for the first clock of every bit so it only moves once SCL is already low.
    sda_oe_d    = sda_oe_q;
`ifdef I2C_MASTER_ACK_CHECK_EN
    ack_d       = ack_q;
`endif

    unique case (state)
      IDLE: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        div_d    = '0;
        if (bus.enable) begin
          addr_d  = {bus.addr, bus.rw};
          data_d  = bus.data_in;
          done_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        sda_oe_d = 1'b1;
        scl_d    = !scl_hi_half;
        if (bit_end) begin
          bit_count_d = 3'd0;
          state_d     = ADDR;
        end
      end
      ADDR, WRITE_DATA: begin
        if (div_q != '0) sda_oe_d = !tx_bit;
        if (bit_end) begin
          bit_count_d = bit_count + 3'd1;
          if (bit_count == 3'd7) state_d = (state == ADDR) ? ADDR_ACK : DATA_ACK;
        end
      end
      READ_DATA: begin
        if (div_q != '0) sda_oe_d = 1'b0;
        if (div_q == HALF) rx_d[3'd7 - bit_count] = sda_in;
        if (bit_end) begin
          bit_count_d = bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            dout_d  = rx_q;
            state_d = DATA_ACK;
          end
        end
      end
      ADDR_ACK: begin
        if (div_q != '0) sda_oe_d = 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
        if (div_q == HALF) ack_d = sda_in;
        if (bit_end) state_d = ack_q ? STOP : (addr_q[0] ? READ_DATA : WRITE_DATA);
`else
        if (bit_end) state_d = addr_q[0] ? READ_DATA : WRITE_DATA;
`endif
      end
      DATA_ACK: begin
        // Read: releasing SDA is the NACK that ends the slave's transmission.
        if (div_q != '0) sda_oe_d = 1'b0;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (div_q != '0) sda_oe_d = (div_q != LAST);
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_count <= 3'd0;
      div_q     <= '0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      rx_q      <= 8'h00;
      dout_q    <= 8'h00;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
      ack_q     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      bit_count <= bit_count_d;
      div_q     <= div_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
`ifdef I2C_MASTER_ACK_CHECK_EN
      ack_q     <= ack_d;
`endif
    end
  end

  assign i2c_scl      = scl_q;
  assign i2c_sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.done     = done_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: bus monitor plus slave model, expected bit stream built from the protocol rules.
`timescale 1ns/1ps
module tb_i2c_master_core;
  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 2 * CLK_DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_master_core_if bus_if ();
  logic i2c_scl;
  wire  i2c_sda;
  logic slv_low;

  pullup (i2c_sda);
  assign i2c_sda = slv_low ? 1'b0 : 1'bz;

  i2c_master_core #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .i2c_scl (i2c_scl),
    .i2c_sda (i2c_sda)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and slave: every SCL rise captures one bit (the STOP rise captures SDA low).
  int          n_start, n_stop, n_cap;
  logic [19:0] cap;
  logic        scl_p = 1'b1, sda_p = 1'b1;
  logic        s_present, s_rw;
  logic [7:0]  s_byte;

  function automatic logic slave_low(input int slot);
    if (!s_present) return 1'b0;
    if (slot == 8) return 1'b1;
    if (slot >= 9 && slot <= 16 && s_rw) return ~s_byte[16 - slot];
    if (slot == 17 && !s_rw) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic scl_n, sda_n;
    scl_n = i2c_scl;
    sda_n = (i2c_sda === 1'b0) ? 1'b0 : 1'b1;
    if (scl_p && scl_n && sda_p && !sda_n) n_start++;
    if (scl_p && scl_n && !sda_p && sda_n) n_stop++;
    if (!scl_p && scl_n) begin
      cap = {cap[18:0], sda_n};
      n_cap++;
    end
    if (scl_p && !scl_n) slv_low = slave_low(n_cap);
    scl_p = scl_n;
    sda_p = sda_n;
  end

  logic [7:0] exp_dout;

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic [7:0] rb, input logic sa, input logic glitch);
    int          cyc;
    logic        early;
    int          exp_n, exp_c;
    logic [19:0] exp_s;
    s_present = sa; s_rw = r; s_byte = rb;
    n_start = 0; n_stop = 0; n_cap = 0; cap = '0;
    bus_if.addr = a; bus_if.rw = r; bus_if.data_in = d; bus_if.enable = 1'b1;
    @(negedge clk);
    bus_if.enable  = 1'b0;
    bus_if.addr    = 7'($urandom);
    bus_if.rw      = 1'($urandom);
    bus_if.data_in = 8'($urandom);
    cyc = 1;
    chk("done_clr", bus_if.done, 1'b0);
    while (!bus_if.done && cyc < 400) begin
      bus_if.enable = (glitch && cyc == 60);
      @(negedge clk);
      cyc++;
    end
    bus_if.enable = 1'b0;
    chk("done_timeout", bus_if.done, 1'b1);

    early = 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
    early = !sa;
`endif
    if (early) begin
      exp_n = 10;
      exp_s = {10'b0, a, r, 1'b1, 1'b0};
      exp_c = 11 * BIT_CLKS;
    end else begin
      exp_n = 19;
      exp_s = {1'b0, a, r, ~sa, (r ? (sa ? rb : 8'hFF) : d), (r ? 1'b1 : ~sa), 1'b0};
      exp_c = 20 * BIT_CLKS;
      if (r) exp_dout = sa ? rb : 8'hFF;
    end
    chk("done_lat", (cyc >= exp_c - 1 && cyc <= exp_c + 1) ? exp_c : cyc, exp_c);

    repeat (3) @(negedge clk);
    chk("n_start", n_start, 1);
    chk("n_stop", n_stop, 1);
    chk("n_bits", n_cap, exp_n);
    chk("bits", cap, exp_s);
    chk("data_out", bus_if.data_out, exp_dout);
    chk("done_held", bus_if.done, 1'b1);
    chk("idle", 32'(dut.state), 3'b000);
  endtask

  initial begin
    rst = 1'b0;
    slv_low = 1'b0; s_present = 1'b0; s_rw = 1'b0; s_byte = 8'h00;
    n_start = 0; n_stop = 0; n_cap = 0; cap = '0;
    bus_if.enable = 1'b0; bus_if.addr = 7'h00; bus_if.rw = 1'b0; bus_if.data_in = 8'h00;
    exp_dout = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scl", i2c_scl, 1'b1);
    chk("rst_sda", i2c_sda, 1'b1);
    chk("rst_done", bus_if.done, 1'b0);
    chk("rst_dout", bus_if.data_out, 8'h00);
    chk("rst_state", 32'(dut.state), 3'b000);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(7'h55, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0);
    run_txn(7'h55, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b1);
    run_txn(7'h2B, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0);
    run_txn(7'h11, 1'b1, 8'h00, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_txn(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    run_txn(7'h6E, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0);

    // Reset while the address byte is being shifted.
    s_present = 1'b0;
    bus_if.addr = 7'h7F; bus_if.rw = 1'b0; bus_if.data_in = 8'hFF; bus_if.enable = 1'b1;
    @(negedge clk);
    bus_if.enable = 1'b0;
    repeat (BIT_CLKS + 10) @(negedge clk);
    chk("mid_addr", 32'(dut.state), 3'b010);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_scl", i2c_scl, 1'b1);
    chk("arst_sda", i2c_sda, 1'b1);
    chk("arst_done", bus_if.done, 1'b0);
    chk("arst_dout", bus_if.data_out, 8'h00);
    chk("arst_state", 32'(dut.state), 3'b000);
    chk("arst_bitcnt", 32'(dut.bit_count), 3'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
